// File: rtl/uart_seq_pkg.sv
// Shared encodings for the UART bus sequencer: core op codes, sequencer
// FSM states and the baud-rate selector values understood by the core.
package uart_seq_pkg;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_CLEAR = 2'd3
  } seq_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2
  } seq_state_t;

  localparam logic [1:0] RATE_DEF    = 2'd0;
  localparam logic [1:0] RATE_9600   = 2'd1;
  localparam logic [1:0] RATE_50000  = 2'd2;
  localparam logic [1:0] RATE_115200 = 2'd3;

endpackage

// File: rtl/uart_seq_rsp_slot.sv
// Single-entry response register. A capture always wins over a consume
// in the same cycle, so freshly read data is never dropped.
module uart_seq_rsp_slot (
  input  logic       clk,
  input  logic       nReset,
  input  logic       capture,
  input  logic [7:0] captureData,
  input  logic       rspReady,
  output logic       rspValid,
  output logic [7:0] rspData
);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rspValid <= 1'b0;
      rspData  <= 8'h00;
    end else if (capture) begin
      rspValid <= 1'b1;
      rspData  <= captureData;
    end else if (rspValid && rspReady) begin
      rspValid <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_bus_sequencer.sv
// Host-side sequencer for the UART core: turns each accepted command into a
// one-cycle op code on control[3:2] followed by a mandatory IDLE cycle.
module uart_bus_sequencer
  import uart_seq_pkg::*;
#(
  parameter int         CNT_W      = 16,
  parameter logic [1:0] RATE_RESET = RATE_DEF
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  input  logic [1:0]       rate_sel,
  output logic [3:0]       control,
  output logic [7:0]       tx_data,
  input  logic [7:0]       rx_data,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] clr_count,
  output seq_state_t       dbg_state
);

  // Handshakes: a transfer happens on the rising clk edge where valid and
  // ready are both 1; valid never waits on ready, ready may depend on valid.
  seq_state_t state, stateNext;
  seq_op_t    opReg;
  seq_op_t    cmdOp;
  logic [1:0] ctrlOp;
  logic [1:0] ctrlRate;
  logic       accept;
  logic       issueAccept;
  logic       capture;

  assign cmdOp       = seq_op_t'(cmd_op);
  assign accept      = cmd_valid && cmd_ready;
  assign issueAccept = accept && (cmdOp != OP_IDLE);
  assign capture     = (state == ST_SETTLE) && (opReg == OP_READ);
  assign control     = {ctrlOp, ctrlRate};
  assign dbg_state   = state;

  always_comb begin
    stateNext = state;
    cmd_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        // A read only stalls while the response slot is full and not draining.
        cmd_ready = nReset && !((cmdOp == OP_READ) && rsp_valid && !rsp_ready);
        if (cmd_valid && cmd_ready && (cmdOp != OP_IDLE)) stateNext = ST_ISSUE;
      end
      ST_ISSUE:  stateNext = ST_SETTLE;
      ST_SETTLE: stateNext = ST_IDLE;
      default:   stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= ST_IDLE;
      opReg     <= OP_IDLE;
      ctrlOp    <= 2'b00;
      ctrlRate  <= RATE_RESET;
      tx_data   <= 8'h00;
      wr_count  <= '0;
      rd_count  <= '0;
      clr_count <= '0;
    end else begin
      state <= stateNext;
      case (state)
        ST_IDLE: begin
          if (issueAccept) begin
            opReg  <= cmdOp;
            ctrlOp <= cmd_op;
            if (cmdOp == OP_WRITE) tx_data <= cmd_wdata;
          end else if (!accept) begin
            ctrlRate <= rate_sel;
          end
        end
        ST_ISSUE: begin
          // The IDLE code must reappear next cycle so the core sees a fresh edge.
          ctrlOp  <= 2'b00;
          tx_data <= 8'h00;
          case (opReg)
            OP_WRITE: wr_count  <= wr_count + CNT_W'(1);
            OP_READ:  rd_count  <= rd_count + CNT_W'(1);
            OP_CLEAR: clr_count <= clr_count + CNT_W'(1);
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  uart_seq_rsp_slot rspSlot (
    .clk         (clk),
    .nReset      (nReset),
    .capture     (capture),
    .captureData (rx_data),
    .rspReady    (rsp_ready),
    .rspValid    (rsp_valid),
    .rspData     (rsp_data)
  );

endmodule

// File: tb/tb_uart_bus_sequencer.sv
// Self-checking bench for uart_bus_sequencer with a behavioural UART core model
// (edge-detected ops, TX/RX byte queues) and a response scoreboard.
module tb_uart_bus_sequencer;
  import uart_seq_pkg::*;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [7:0]  cmd_wdata = 8'h00;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic [1:0]  rate_sel = 2'd0;
  logic [3:0]  control;
  logic [7:0]  tx_data;
  logic [7:0]  rx_data = 8'h00;
  logic [15:0] wr_count, rd_count, clr_count;
  seq_state_t  dbg_state;

  int n_cmp = 0;
  int n_fail = 0;
  int m_wr = 0, m_rd = 0, m_clr = 0;
  logic [7:0] exp_q[$];
  logic [7:0] core_rx_q[$];
  logic [7:0] core_tx_q[$];
  int core_ops = 0;
  int core_op_cycles = 0;
  logic [1:0] prev_op = 2'd0;
  int pop_cd = 0;

  uart_bus_sequencer dut (
    .clk(clk), .nReset(nReset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rate_sel(rate_sel), .control(control), .tx_data(tx_data),
    .rx_data(rx_data), .wr_count(wr_count), .rd_count(rd_count), .clr_count(clr_count),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Core model: acts on IDLE->op transitions, pops RX after the read completes.
  always @(negedge clk) begin
    logic [1:0] cur;
    cur = control[3:2];
    if (pop_cd > 0) begin
      pop_cd--;
      if (pop_cd == 0 && core_rx_q.size() > 0) void'(core_rx_q.pop_front());
    end
    if (cur != 2'd0) core_op_cycles++;
    if (prev_op == 2'd0 && cur != 2'd0) begin
      core_ops++;
      if (cur == 2'd1) core_tx_q.push_back(tx_data);
      if (cur == 2'd2) pop_cd = 2;
    end
    prev_op = cur;
    rx_data = (core_rx_q.size() > 0) ? core_rx_q[0] : 8'h00;
  end

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] d);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_wdata = d;
    #1;
    n = 0;
    while (!cmd_ready && n < 40) begin @(negedge clk); #1; n++; end
    if (!cmd_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout op=%0d got ready=0 exp ready=1", op);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic take_rsp(input string tag);
    int n;
    logic [7:0] e;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); #1; n++; end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_data !== e) begin
      n_fail++;
      $display("FAIL %s got valid=%b data=%h exp valid=1 data=%h", tag, rsp_valid, rsp_data, e);
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_drain got valid=%b exp 0", tag, rsp_valid);
    end
  endtask

  task automatic test_reset;
    cmd_valid = 1'b1; cmd_op = 2'd1;
    #23;
    n_cmp++;
    if ({cmd_ready, control, tx_data, rsp_valid, rsp_data, wr_count, rd_count, clr_count, dbg_state}
        !== {1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 48'h0, ST_IDLE}) begin
      n_fail++;
      $display("FAIL reset_values got rdy=%b ctl=%h tx=%h rv=%b rd=%h cnt=%h/%h/%h st=%0d exp all zero",
               cmd_ready, control, tx_data, rsp_valid, rsp_data, wr_count, rd_count, clr_count, dbg_state);
    end
    @(negedge clk); cmd_valid = 1'b0; nReset = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({cmd_ready, control} !== {1'b1, 4'h0}) begin
      n_fail++; $display("FAIL reset_release got rdy=%b ctl=%h exp rdy=1 ctl=0", cmd_ready, control);
    end
  endtask

  task automatic test_write_single(input string tag);
    int base_ops, base_tx;
    base_ops = core_ops; base_tx = core_tx_q.size();
    send_cmd(2'd1, 8'hA5); m_wr++;
    n_cmp++;
    if ({control[3:2], tx_data} !== {2'b01, 8'hA5}) begin
      n_fail++; $display("FAIL %s_issue got op=%b tx=%h exp op=01 tx=a5", tag, control[3:2], tx_data);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({control[3:2], tx_data, wr_count} !== {2'b00, 8'h00, 16'(m_wr)}) begin
      n_fail++;
      $display("FAIL %s_settle got op=%b tx=%h wr=%0d exp op=00 tx=00 wr=%0d", tag, control[3:2], tx_data, wr_count, m_wr);
    end
    @(posedge clk); @(negedge clk); #1;
    n_cmp++;
    if (core_ops - base_ops !== 1 || core_tx_q.size() !== base_tx + 1 || core_tx_q[core_tx_q.size()-1] !== 8'hA5) begin
      n_fail++; $display("FAIL %s_core got ops=%0d txq=%0d exp ops=1 last=a5", tag, core_ops - base_ops, core_tx_q.size() - base_tx);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b[3];
    int idx, base_ops, base_cyc, base_tx;
    logic acc;
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33;
    idx = 0; base_ops = core_ops; base_cyc = core_op_cycles; base_tx = core_tx_q.size();
    cmd_op = 2'd1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      cmd_valid = (idx < 3);
      if (idx < 3) cmd_wdata = b[idx];
      #1;
      n_cmp++;
      if (cmd_ready !== ((c % 3) == 0)) begin
        n_fail++; $display("FAIL b2b_ready cyc%0d got %b exp %b", c, cmd_ready, (c % 3) == 0);
      end
      acc = cmd_valid && cmd_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    cmd_valid = 1'b0;
    m_wr += 3;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (core_ops - base_ops !== 3 || core_op_cycles - base_cyc !== 3) begin
      n_fail++; $display("FAIL b2b_separation got ops=%0d opcycles=%0d exp 3/3", core_ops - base_ops, core_op_cycles - base_cyc);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (core_tx_q.size() <= base_tx + i || core_tx_q[base_tx + i] !== b[i]) begin
        n_fail++; $display("FAIL b2b_order idx%0d got size=%0d exp byte=%h", i, core_tx_q.size(), b[i]);
      end
    end
  endtask

  task automatic test_read_single;
    core_rx_q.push_back(8'h5C); exp_q.push_back(8'h5C);
    send_cmd(2'd2, 8'h00); m_rd++;
    n_cmp++;
    if ({control[3:2], rsp_valid} !== {2'b10, 1'b0}) begin
      n_fail++; $display("FAIL read_issue got op=%b rv=%b exp op=10 rv=0", control[3:2], rsp_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL read_early got rv=%b exp 0", rsp_valid); end
    @(posedge clk); #1;
    n_cmp++;
    if ({rsp_valid, rsp_data, rd_count} !== {1'b1, 8'h5C, 16'(m_rd)}) begin
      n_fail++; $display("FAIL read_latency got rv=%b data=%h rd=%0d exp rv=1 data=5c rd=%0d", rsp_valid, rsp_data, rd_count, m_rd);
    end
    take_rsp("read_rsp");
  endtask

  task automatic test_read_stall;
    logic [7:0] e;
    core_rx_q.push_back(8'h01); core_rx_q.push_back(8'h02);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    send_cmd(2'd2, 8'h00); m_rd++;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_wdata = 8'h00;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready cyc%0d got %b exp 0", i, cmd_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if ({cmd_ready, rsp_valid, rsp_data} !== {1'b1, 1'b1, e}) begin
      n_fail++; $display("FAIL stall_release got rdy=%b rv=%b data=%h exp rdy=1 rv=1 data=%h", cmd_ready, rsp_valid, rsp_data, e);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0; cmd_valid = 1'b0; m_rd++;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_consumed got rv=%b exp 0", rsp_valid); end
    take_rsp("stall_second");
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_dup got rv=%b exp 0", rsp_valid); end
  endtask

  task automatic test_rate_clear;
    @(negedge clk); rate_sel = 2'b00;
    send_cmd(2'd3, 8'h00); m_clr++;
    n_cmp++;
    if (control !== 4'b1100) begin n_fail++; $display("FAIL clear_issue got ctl=%b exp 1100", control); end
    rate_sel = 2'b11;
    @(posedge clk); #1;
    n_cmp++;
    if ({control, clr_count} !== {4'b0000, 16'(m_clr)}) begin
      n_fail++; $display("FAIL rate_settle got ctl=%b clr=%0d exp ctl=0000 clr=%0d", control, clr_count, m_clr);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (control !== 4'b0000) begin n_fail++; $display("FAIL rate_first_idle got ctl=%b exp 0000", control); end
    @(posedge clk); #1;
    n_cmp++;
    if (control !== 4'b0011) begin n_fail++; $display("FAIL rate_applied got ctl=%b exp 0011", control); end
    rate_sel = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [1:0] op, r;
    logic [7:0] d, v;
    logic [7:0] writes[$];
    core_tx_q.delete();
    for (int i = 0; i < 24; i++) begin
      r = 2'($urandom_range(0, 3));
      op = 2'($urandom_range(0, 3));
      d = 8'($urandom_range(0, 255));
      @(negedge clk); rate_sel = r;
      @(negedge clk); #1;
      n_cmp++;
      if (control[1:0] !== r) begin n_fail++; $display("FAIL rand_rate it%0d got %b exp %b", i, control[1:0], r); end
      if (op == 2'd2) begin
        v = 8'($urandom_range(0, 255));
        core_rx_q.push_back(v); exp_q.push_back(v);
      end
      send_cmd(op, d);
      case (op)
        2'd1: begin m_wr++; writes.push_back(d); end
        2'd2: m_rd++;
        2'd3: m_clr++;
        default: ;
      endcase
      n_cmp++;
      if (control[3:2] !== op) begin n_fail++; $display("FAIL rand_issue it%0d got op=%b exp %b", i, control[3:2], op); end
      @(posedge clk); @(posedge clk); #1;
      if (op == 2'd2) take_rsp("rand_rsp");
    end
    n_cmp++;
    if ({wr_count, rd_count, clr_count} !== {16'(m_wr), 16'(m_rd), 16'(m_clr)}) begin
      n_fail++;
      $display("FAIL rand_counters got %0d/%0d/%0d exp %0d/%0d/%0d", wr_count, rd_count, clr_count, m_wr, m_rd, m_clr);
    end
    n_cmp++;
    if (core_tx_q.size() !== writes.size()) begin
      n_fail++; $display("FAIL rand_write_count got %0d exp %0d", core_tx_q.size(), writes.size());
    end else begin
      for (int i = 0; i < writes.size(); i++) begin
        n_cmp++;
        if (core_tx_q[i] !== writes[i]) begin
          n_fail++; $display("FAIL rand_write_data idx%0d got %h exp %h", i, core_tx_q[i], writes[i]);
        end
      end
    end
    @(negedge clk); rate_sel = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset_midop;
    core_rx_q.push_back(8'hAA); exp_q.push_back(8'hAA);
    send_cmd(2'd2, 8'h00); m_rd++;
    @(posedge clk); @(posedge clk); #1;
    n_cmp++;
    if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL midop_pending got rv=%b exp 1", rsp_valid); end
    send_cmd(2'd1, 8'h77);
    #2 nReset = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_ready, control, tx_data, rsp_valid, rsp_data, wr_count, rd_count, clr_count, dbg_state}
        !== {1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 48'h0, ST_IDLE}) begin
      n_fail++;
      $display("FAIL midop_reset got rdy=%b ctl=%h tx=%h rv=%b rd=%h cnt=%h/%h/%h st=%0d exp all zero",
               cmd_ready, control, tx_data, rsp_valid, rsp_data, wr_count, rd_count, clr_count, dbg_state);
    end
    @(negedge clk); nReset = 1'b1;
    m_wr = 0; m_rd = 0; m_clr = 0;
    exp_q.delete(); core_rx_q.delete();
    @(negedge clk);
    test_write_single("after_reset");
  endtask

  initial begin
    test_reset;
    test_write_single("write_a5");
    test_back_to_back;
    test_read_single;
    test_read_stall;
    test_rate_clear;
    test_random;
    test_reset_midop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
